booth_radix4_mult: RTL

//  Parametrised sequential radix-4 (modified) Booth multiplier. Successor to the radix-2
//  16-bit Booth datapath/controller pair. Retires 2 multiplier bits per clock, handles

---
 rtl/booth_pkg.sv | 40 ++++
 rtl/booth_r4_recoder.sv | 44 ++++
 rtl/booth_radix4_mult.sv | 126 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Purpose: shared FSM state and Booth digit types for the radix-4 multiplier.
// Latency: none (types and a pure combinational recode function).
// Backpressure: not applicable.
//
// Contents:
//   state_t        IDLE / CALC / DONE controller states
//   booth_digit_t  signed Booth digit as sign + one-hot magnitude {x2, x1}
//   booth_recode   {q1, q0, q_m1} -> booth_digit_t, independent of operand width
package booth_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Digit value is (neg ? -1 : +1) * (x2 ? 2 : x1 ? 1 : 0).
  // A zero digit always has neg=0, so the adder carry-in stays clean.
  typedef struct packed {
    logic neg;
    logic x2;
    logic x1;
  } booth_digit_t;

  localparam int RECODE_BITS = 3;

  function automatic booth_digit_t booth_recode(input logic [RECODE_BITS-1:0] bits);
    booth_digit_t d;
    d = '{neg: 1'b0, x2: 1'b0, x1: 1'b0};
    case (bits)
      3'b001, 3'b010: d = '{neg: 1'b0, x2: 1'b0, x1: 1'b1};
      3'b011:         d = '{neg: 1'b0, x2: 1'b1, x1: 1'b0};
      3'b100:         d = '{neg: 1'b1, x2: 1'b1, x1: 1'b0};
      3'b101, 3'b110: d = '{neg: 1'b1, x2: 1'b0, x1: 1'b1};
      default:        d = '{neg: 1'b0, x2: 1'b0, x1: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Purpose: recode one radix-4 Booth window and select the matching multiple of M.
// Latency: combinational.
// Backpressure: not applicable.
//
// Ports:
//   bits  in   3        {Q[1:0], q_m1} window of the multiplier
//   m     in   WIDTH+2  extended multiplicand
//   dig   out  3        recoded digit {neg, x2, x1}
//   pp    out  WIDTH+3  selected multiple, bitwise inverted when dig.neg=1;
//                       the adder supplies dig.neg as carry-in to finish the
//                       two's-complement negation
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       bits,
  input  logic [WIDTH+1:0] m,
  output booth_digit_t     dig,
  output logic [WIDTH+2:0] pp
);

  logic [WIDTH+2:0] m_x1;
  logic [WIDTH+2:0] m_x2;
  logic [WIDTH+2:0] mag;

  assign dig  = booth_recode(bits);

  // Sign-extend one bit so that 2M of any in-range M stays representable.
  assign m_x1 = {m[WIDTH+1], m};
  assign m_x2 = {m, 1'b0};

  always_comb begin
    mag = '0;
    if (dig.x2) begin
      mag = m_x2;
    end else if (dig.x1) begin
      mag = m_x1;
    end
  end

  assign pp = mag ^ {(WIDTH+3){dig.neg}};

endmodule

// File: rtl/booth_radix4_mult.sv
// Purpose: sequential radix-4 Booth multiplier, signed or unsigned per transaction.
// Latency: start sampled at edge E0 -> done pulse and product after edge E0+WIDTH/2+2.
// Backpressure: start is only accepted while ready=1; requests while busy are dropped.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-low reset
//   start      in   1        request, sampled while ready=1
//   is_signed  in   1        1: two's-complement operands, 0: unsigned
//   in1        in   WIDTH    multiplicand
//   in2        in   WIDTH    multiplier
//   ready      out  1        idle, can accept start
//   busy       out  1        operation in flight (CALC or DONE)
//   done       out  1        one-cycle pulse, out holds the new product
//   out        out  2*WIDTH  product, held until the next done or reset
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  // The extended multiplier is WIDTH+2 bits (even), so WIDTH/2+1 digits cover it.
  localparam int NITER = WIDTH / 2 + 1;
  localparam int CW    = $clog2(NITER + 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("booth_radix4_mult: WIDTH must be even and >= 4");
  end

  state_t           state;
  logic [WIDTH+2:0] acc;     // A: one guard bit beyond M so +/-2M never overflows
  logic [WIDTH+1:0] q;       // Q: multiplier, low product bits shift in from A
  logic [WIDTH+1:0] m;       // M: multiplicand, extended per is_signed
  logic             q_m1;
  logic [CW-1:0]    count;

  booth_digit_t     dig;
  logic [WIDTH+2:0] pp;
  logic [WIDTH+2:0] sum;
  logic [WIDTH+2:0] acc_nxt;

  booth_r4_recoder #(
    .WIDTH (WIDTH)
  ) u_recoder (
    .bits ({q[1:0], q_m1}),
    .m    (m),
    .dig  (dig),
    .pp   (pp)
  );

  // pp arrives one's-complemented for negative digits; dig.neg is the +1.
  assign sum = acc + pp + (WIDTH+3)'(dig.neg);

  // Zero digits leave A untouched so the adder result is not propagated.
  assign acc_nxt = (dig.x1 || dig.x2) ? sum : acc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= is_signed ? {{2{in1[WIDTH-1]}}, in1} : {2'b00, in1};
            q     <= is_signed ? {{2{in2[WIDTH-1]}}, in2} : {2'b00, in2};
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= CW'(NITER);
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end

        S_CALC: begin
          // Add the digit multiple, then arithmetic-shift {A,Q,q_m1} right by 2.
          acc   <= {{2{acc_nxt[WIDTH+2]}}, acc_nxt[WIDTH+2:2]};
          q     <= {acc_nxt[1:0], q[WIDTH+1:2]};
          q_m1  <= q[1];
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          // Low 2*WIDTH bits of {A,Q}; Q already supplies WIDTH+2 of them.
          out   <= {acc[WIDTH-3:0], q};
          done  <= 1'b1;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
